// File: rtl/fifo_credit_tx_pkg.sv
// Shared types for the credit-flow-controlled FIFO-to-link transmitter.
package fifo_tx_pkg;

  typedef enum logic [1:0] {
    BODY      = 2'b00,
    HEAD      = 2'b01,
    TAIL      = 2'b10,
    HEAD_TAIL = 2'b11
  } flit_type_t;

  typedef enum logic {
    IDLE   = 1'b0,
    IN_PKT = 1'b1
  } tx_state_t;

  // Flit type occupies the top FLIT_TYPE_MSB+1 bits of every flit.
  localparam int unsigned FLIT_TYPE_MSB = 1;

endpackage

// File: rtl/fifo_credit_tx_if.sv
// FIFO-side and link-side signals of fifo_credit_tx; master is the transmitter view.
interface fifo_credit_tx_if #(
  parameter int unsigned WIDTH   = 34,
  parameter int unsigned CREDITS = 2
);
  localparam int unsigned CW = $clog2(CREDITS + 1);

  logic             en_i;
  logic             fifo_empty_i;
  logic [WIDTH-1:0] fifo_data_i;
  logic             fifo_rd_o;
  logic             link_vld_o;
  logic [WIDTH-1:0] link_data_o;
  logic             link_credit_i;
  logic [CW-1:0]    credits_o;
  logic             lock_o;
  logic             err_o;

  modport master (
    input  en_i, fifo_empty_i, fifo_data_i, link_credit_i,
    output fifo_rd_o, link_vld_o, link_data_o, credits_o, lock_o, err_o
  );

  modport slave (
    output en_i, fifo_empty_i, fifo_data_i, link_credit_i,
    input  fifo_rd_o, link_vld_o, link_data_o, credits_o, lock_o, err_o
  );
endinterface

// File: rtl/fifo_credit_tx_credit_counter.sv
// Downstream credit counter: resets full, saturates at CREDITS, flags a return while full.
module credit_counter #(
  parameter int unsigned CREDITS = 2,
  localparam int unsigned CW     = $clog2(CREDITS + 1)
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          consume_i,
  input  logic          return_i,
  output logic [CW-1:0] count_o,
  output logic          avail_o,
  output logic          ovf_o
);
  logic [CW-1:0] r_count;
  logic          w_full;

  assign w_full  = (r_count == CW'(CREDITS));
  assign count_o = r_count;
  assign avail_o = (r_count != '0);
  assign ovf_o   = return_i & ~consume_i & w_full;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_count <= CW'(CREDITS);
    end else if (consume_i && !return_i) begin
      r_count <= r_count - CW'(1);
    end else if (return_i && !consume_i && !w_full) begin
      r_count <= r_count + CW'(1);
    end
  end
endmodule

// File: rtl/fifo_credit_tx.sv
// Drains a router input FIFO onto a credit-controlled link and tracks packet framing.
// Optional protocol checker enabled by defining FIFO_CREDIT_TX_CHECK_EN.
module fifo_credit_tx
  import fifo_tx_pkg::*;
#(
  parameter int unsigned WIDTH   = 34,
  parameter int unsigned CREDITS = 2
) (
  input  logic           clk,
  input  logic           arst,
  fifo_credit_tx_if.master bus
);
  localparam int unsigned CW = $clog2(CREDITS + 1);

  logic             w_pop;
  logic             w_avail;
  logic             w_ovf;
  logic [CW-1:0]    w_count;
  flit_type_t       w_type;
  tx_state_t        r_state;
  logic             r_link_vld;
  logic [WIDTH-1:0] r_link_data;

  credit_counter #(.CREDITS(CREDITS)) u_credit (
    .clk       (clk),
    .arst      (arst),
    .consume_i (w_pop),
    .return_i  (bus.link_credit_i),
    .count_o   (w_count),
    .avail_o   (w_avail),
    .ovf_o     (w_ovf)
  );

  // Pop uses only the registered count; a credit returning this cycle helps next cycle.
  assign w_pop  = ~arst & bus.en_i & ~bus.fifo_empty_i & w_avail;
  assign w_type = flit_type_t'(bus.fifo_data_i[WIDTH-1 -: FLIT_TYPE_MSB+1]);

  assign bus.fifo_rd_o   = w_pop;
  assign bus.credits_o   = w_count;
  assign bus.link_vld_o  = r_link_vld;
  assign bus.link_data_o = r_link_data;
  assign bus.lock_o      = (r_state == IN_PKT) |
                           (w_pop & (r_state == IDLE) & (w_type == HEAD));

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_state     <= IDLE;
      r_link_vld  <= 1'b0;
      r_link_data <= '0;
    end else begin
      r_link_vld  <= w_pop;
      r_link_data <= w_pop ? bus.fifo_data_i : '0;
      if (w_pop) begin
        case (r_state)
          IDLE:    if (w_type == HEAD) r_state <= IN_PKT;
          IN_PKT:  if (w_type == TAIL || w_type == HEAD_TAIL) r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

`ifdef FIFO_CREDIT_TX_CHECK_EN
  logic r_err;
  logic w_err;

  assign w_err = (w_pop & (r_state == IDLE)   & (w_type == BODY || w_type == TAIL)) |
                 (w_pop & (r_state == IN_PKT) & (w_type == HEAD)) |
                 w_ovf;

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_err;
    end
  end

  assign bus.err_o = r_err;
`else
  logic w_unused_ovf;
  assign w_unused_ovf = w_ovf;
  assign bus.err_o    = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_credit_tx.sv
// Scoreboard bench for fifo_credit_tx (WIDTH=34, CREDITS=2); directed per-cycle FIFO/link vectors.
module tb_fifo_credit_tx;
  localparam int unsigned WIDTH   = 34;
  localparam int unsigned CREDITS = 2;
`ifdef FIFO_CREDIT_TX_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  typedef struct {
    int unsigned      cyc;
    logic [WIDTH-1:0] data;
  } sb_entry_t;

  logic        clk;
  logic        arst;
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned failures = 0;
  sb_entry_t   sb[$];

  fifo_credit_tx_if #(.WIDTH(WIDTH), .CREDITS(CREDITS)) bus ();

  fifo_credit_tx #(.WIDTH(WIDTH), .CREDITS(CREDITS)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Monitor: every link flit must match the next scoreboard entry in data and cycle.
  always @(posedge clk) begin
    sb_entry_t e;
    cyc++;
    #1;
    if (bus.link_vld_o === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL link_unexpected got=%0h exp=none (cycle %0d)", bus.link_data_o, cyc);
      end else begin
        e = sb.pop_front();
        chk("link_data", 64'(bus.link_data_o), 64'(e.data));
        chk("link_cycle", 64'(cyc), 64'(e.cyc));
      end
    end else begin
      chk("link_idle_data", 64'(bus.link_data_o), 64'd0);
    end
  end

  task automatic drive(input logic rst, input logic en, input logic empty,
                       input logic [WIDTH-1:0] data, input logic credit);
    @(negedge clk);
    arst              = rst;
    bus.en_i          = en;
    bus.fifo_empty_i  = empty;
    bus.fifo_data_i   = data;
    bus.link_credit_i = credit;
    #1;
  endtask

  task automatic exp_pop(input logic [WIDTH-1:0] data);
    sb_entry_t e;
    chk("fifo_rd_pop", 64'(bus.fifo_rd_o), 64'd1);
    e.cyc  = cyc + 1;
    e.data = data;
    sb.push_back(e);
  endtask

  task automatic st(input string tag, input logic [1:0] credits, input logic lock);
    chk({tag, "_credits"}, 64'(bus.credits_o), 64'(credits));
    chk({tag, "_lock"}, 64'(bus.lock_o), 64'(lock));
  endtask

  initial begin
    arst              = 1'b1;
    bus.en_i          = 1'b0;
    bus.fifo_empty_i  = 1'b1;
    bus.fifo_data_i   = '0;
    bus.link_credit_i = 1'b0;

    // Reset held with a grant and a non-empty FIFO
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 34'h1_0000_00AA, 0);
      chk("rst_fifo_rd", 64'(bus.fifo_rd_o), 64'd0);
      st("rst", 2'd2, 1'b0);
      chk("rst_link_vld", 64'(bus.link_vld_o), 64'd0);
      chk("rst_err", 64'(bus.err_o), 64'd0);
    end

    // HEAD, BODY pop; TAIL stalls on zero credits
    drive(0, 1, 0, 34'h1_0000_00AA, 0); exp_pop(34'h1_0000_00AA); st("head", 2'd2, 1'b1);
    drive(0, 1, 0, 34'h0_0000_00BB, 0); exp_pop(34'h0_0000_00BB); st("body", 2'd1, 1'b1);
    drive(0, 1, 0, 34'h2_0000_00CC, 0);
    chk("stall_rd", 64'(bus.fifo_rd_o), 64'd0); st("stall", 2'd0, 1'b1);
    drive(0, 1, 0, 34'h2_0000_00CC, 1);
    chk("bypass_rd", 64'(bus.fifo_rd_o), 64'd0); st("bypass", 2'd0, 1'b1);
    drive(0, 1, 0, 34'h2_0000_00CC, 0); exp_pop(34'h2_0000_00CC); st("tail", 2'd1, 1'b1);
    drive(0, 1, 1, '0, 0);
    chk("post_tail_rd", 64'(bus.fifo_rd_o), 64'd0); st("post_tail", 2'd0, 1'b0);
    chk("post_tail_err", 64'(bus.err_o), 64'd0);

    // Simultaneous pop + credit, then saturation
    drive(0, 1, 1, '0, 1);                st("ret0", 2'd0, 1'b0);
    drive(0, 1, 0, 34'h3_0000_0022, 1);   exp_pop(34'h3_0000_0022); st("popret", 2'd1, 1'b0);
    drive(0, 1, 1, '0, 0);                st("popret_after", 2'd1, 1'b0);
    drive(0, 1, 1, '0, 1);                st("ret1", 2'd1, 1'b0);
    drive(0, 1, 1, '0, 1);                st("sat_in", 2'd2, 1'b0);
    drive(0, 1, 1, '0, 0);                st("sat_out", 2'd2, 1'b0);
    chk("ovf_err", 64'(bus.err_o), 64'(EXP_ERR));
    drive(0, 1, 1, '0, 0);
    chk("ovf_err_clear", 64'(bus.err_o), 64'd0);

    // Single HEAD_TAIL never locks
    drive(0, 1, 0, 34'h3_0000_0011, 0);   exp_pop(34'h3_0000_0011); st("ht", 2'd2, 1'b0);
    drive(0, 1, 1, '0, 0);                st("ht_after", 2'd1, 1'b0);
    chk("ht_err", 64'(bus.err_o), 64'd0);
    drive(0, 1, 1, '0, 1);

    // Reset mid-packet, grant dropped
    drive(0, 1, 0, 34'h1_0000_0055, 0);   exp_pop(34'h1_0000_0055); st("pkt", 2'd2, 1'b1);
    drive(1, 0, 0, 34'h0_0000_0066, 0);
    st("midrst", 2'd2, 1'b0);
    chk("midrst_vld", 64'(bus.link_vld_o), 64'd0);
    chk("midrst_data", 64'(bus.link_data_o), 64'd0);
    chk("midrst_rd", 64'(bus.fifo_rd_o), 64'd0);
    drive(1, 0, 1, '0, 0);
    drive(0, 1, 0, 34'h1_0000_0088, 0);   exp_pop(34'h1_0000_0088); st("fresh", 2'd2, 1'b1);
    chk("fresh_err", 64'(bus.err_o), 64'd0);
    drive(0, 1, 0, 34'h2_0000_0099, 0);   exp_pop(34'h2_0000_0099); st("fresh_tail", 2'd1, 1'b1);
    drive(0, 1, 1, '0, 1);                st("fresh_done", 2'd0, 1'b0);
    chk("fresh_tail_err", 64'(bus.err_o), 64'd0);
    drive(0, 1, 1, '0, 1);                st("refill", 2'd1, 1'b0);

    // BODY popped in IDLE
    drive(0, 1, 0, 34'h0_0000_00BD, 0);   exp_pop(34'h0_0000_00BD); st("orphan", 2'd2, 1'b0);
    drive(0, 1, 1, '0, 0);                st("orphan_after", 2'd1, 1'b0);
    chk("orphan_err", 64'(bus.err_o), 64'(EXP_ERR));
    drive(0, 1, 1, '0, 0);                st("orphan_idle", 2'd1, 1'b0);
    chk("orphan_err_clear", 64'(bus.err_o), 64'd0);

    drive(0, 0, 1, '0, 0);
    drive(0, 0, 1, '0, 0);
    chk("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
